// File: rtl/gen_seq_pkg.sv
// Shared definitions for the 6-bit sync sequence generator.
// Holds the FSM state enum, the sync pattern and its length, and a helper
// that sizes the bit counter. Optional macro: GEN_SEQ_PARITY_EN adds the PAR state.
package gen_seq_pkg;

  localparam int unsigned SYNC_LEN = 6;
  localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 6'b110011;

`ifdef GEN_SEQ_PARITY_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;
`endif

  // Counter must hold 0..max(SYNC_LEN, payload_w) without wrapping.
  function automatic int unsigned cnt_width(input int unsigned payload_w);
    int unsigned m;
    m = (payload_w > SYNC_LEN) ? payload_w : SYNC_LEN;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/generate_6_bit_sequence_using_fsm_if.sv
// Request/stream bundle for the sequence generator.
// start_valid/start_ready/payload : frame request handshake (master -> slave)
// a/busy/last_bit                 : serial stream and framing flags (slave -> master)
interface generate_6_bit_sequence_using_fsm_if #(
  parameter int unsigned PAYLOAD_W = 8
);

  logic                 start_valid;
  logic                 start_ready;
  logic [PAYLOAD_W-1:0] payload;
  logic                 a;
  logic                 busy;
  logic                 last_bit;

  modport master (
    output start_valid, payload,
    input  start_ready, a, busy, last_bit
  );

  modport slave (
    input  start_valid, payload,
    output start_ready, a, busy, last_bit
  );

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: parallel load, MSB-first left shift.
// Ports: clk, rst_n (async active-low clear), load_i, shift_i, data_i,
//        msb_o (current MSB), nxt_msb_o (MSB after one shift).
module piso_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o,
  output logic             nxt_msb_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] shifted;

  assign shifted = q_q << 1;

  // Load has priority; shift only advances when asked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= data_i;
    end else if (shift_i) begin
      q_q <= shifted;
    end
  end

  assign msb_o     = q_q[WIDTH-1];
  assign nxt_msb_o = shifted[WIDTH-1];

endmodule

// File: rtl/generate_6_bit_sequence_using_fsm.sv
// Frame generator: on each accepted request, emits sync 110011, then the
// latched payload MSB-first, then (GEN_SEQ_PARITY_EN) one even-parity bit.
// Ports: clk, rst_n (async active-low), bus (slave modport: start_valid,
//        start_ready, payload, a, busy, last_bit).
// Optional macro: GEN_SEQ_PARITY_EN.
module generate_6_bit_sequence_using_fsm #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  generate_6_bit_sequence_using_fsm_if.slave    bus
);

  import gen_seq_pkg::*;

  localparam int unsigned CNT_W = cnt_width(PAYLOAD_W);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             load, shift;
  logic             sh_msb, sh_nxt_msb;
`ifdef GEN_SEQ_PARITY_EN
  logic             par_q;
`endif

  piso_shift_reg #(.WIDTH(PAYLOAD_W)) u_piso (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .shift_i   (shift),
    .data_i    (bus.payload),
    .msb_o     (sh_msb),
    .nxt_msb_o (sh_nxt_msb)
  );

  // State/counter register; state_q names the bit currently on a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

`ifdef GEN_SEQ_PARITY_EN
  // Parity captured at acceptance so it reflects the latched payload only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^bus.payload;
    end
  end
`endif

  // Next-state plus registered-output precompute from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    a_d     = 1'b0;
    busy_d  = 1'b0;
    last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          state_d = SYNC;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
`ifdef GEN_SEQ_PARITY_EN
          state_d = PAR;
`else
          state_d = IDLE;
`endif
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          shift = 1'b1;
        end
      end
`ifdef GEN_SEQ_PARITY_EN
      PAR: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      SYNC: begin
        a_d    = SYNC_PATTERN[3'(SYNC_LEN - 1) - 3'(cnt_d)];
        busy_d = 1'b1;
      end
      DATA: begin
        // Staying in DATA means the register shifts on this edge.
        a_d    = (state_q == DATA) ? sh_nxt_msb : sh_msb;
        busy_d = 1'b1;
`ifndef GEN_SEQ_PARITY_EN
        last_d = (cnt_d == DATA_LAST);
`endif
      end
`ifdef GEN_SEQ_PARITY_EN
      PAR: begin
        a_d    = par_q;
        busy_d = 1'b1;
        last_d = 1'b1;
      end
`endif
      default: begin
        a_d    = 1'b0;
        busy_d = 1'b0;
        last_d = 1'b0;
      end
    endcase
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.a           = a_q;
  assign bus.busy        = busy_q;
  assign bus.last_bit    = last_q;

endmodule

// File: tb/tb_generate_6_bit_sequence_using_fsm.sv
// Self-checking bench for generate_6_bit_sequence_using_fsm.
// Expected frames come from a bit-queue model: sync bits, payload MSB-first,
// optional even parity (GEN_SEQ_PARITY_EN).
module tb_generate_6_bit_sequence_using_fsm;

  localparam int unsigned PW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  generate_6_bit_sequence_using_fsm_if #(.PAYLOAD_W(PW)) bus ();

  generate_6_bit_sequence_using_fsm #(.PAYLOAD_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_q[$];

  // Loopback 110011 detector on the serial stream.
  logic [5:0] det_hist = '0;
  int         det_cnt  = 0;
  always @(negedge clk) begin
    det_hist = {det_hist[4:0], bus.a};
    if (det_hist == 6'b110011) det_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void build_frame(input logic [PW-1:0] p);
    logic [5:0] s;
    s = 6'b110011;
    exp_q.delete();
    for (int i = 5; i >= 0; i--) exp_q.push_back(s[i]);
    for (int i = int'(PW) - 1; i >= 0; i--) exp_q.push_back(p[i]);
`ifdef GEN_SEQ_PARITY_EN
    exp_q.push_back(^p);
`endif
  endfunction

  // Checks every bit of a frame accepted at the coming posedge.
  task automatic expect_frame(input logic [PW-1:0] p, input bit hold,
                              input logic [PW-1:0] p_after, input string tag);
    build_frame(p);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (!hold) bus.start_valid = 1'b0;
        bus.payload = p_after;
      end
      chk({tag, "/a"},     bus.a, exp_q[i]);
      chk({tag, "/busy"},  bus.busy, 1);
      chk({tag, "/last"},  bus.last_bit, (i == exp_q.size() - 1));
      chk({tag, "/ready"}, bus.start_ready, 0);
    end
  endtask

  task automatic gap_check(input string tag);
    @(negedge clk);
    chk({tag, "/gap_a"},     bus.a, 0);
    chk({tag, "/gap_busy"},  bus.busy, 0);
    chk({tag, "/gap_last"},  bus.last_bit, 0);
    chk({tag, "/gap_ready"}, bus.start_ready, 1);
  endtask

  task automatic send(input logic [PW-1:0] p, input bit hold,
                      input logic [PW-1:0] p_after, input string tag);
    int t;
    t = 0;
    while (bus.start_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "/ready_wait"}, (t < 64), 1);
    bus.start_valid = 1'b1;
    bus.payload     = p;
    expect_frame(p, hold, p_after, tag);
    gap_check(tag);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk({tag, "/idle_a"},    bus.a, 0);
      chk({tag, "/idle_busy"}, bus.busy, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.start_valid = 1'b0;
    bus.payload     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst/a", bus.a, 0);
    chk("rst/busy", bus.busy, 0);
    chk("rst/last", bus.last_bit, 0);
    chk("rst/ready", bus.start_ready, 1);
    rst_n = 1'b1;
    idle_cycles(2, "post_rst");

    // Directed A5 frame, then payload changed to FF right after acceptance
    send(8'hA5, 1'b0, PW'($urandom), "a5");
    idle_cycles(1, "a5");
    send(8'hA5, 1'b0, 8'hFF, "chg");

    // start_valid held high: frames separated by exactly one idle bit
    for (int k = 0; k < 3; k++) send(PW'($urandom), 1'b1, PW'($urandom), "b2b");
    bus.start_valid = 1'b0;

    // Loopback detector, payload 00: one detection per frame
    idle_cycles(8, "det");
    d0 = det_cnt;
    for (int k = 0; k < 3; k++) begin
      send(8'h00, 1'b1, 8'h00, "det");
      chk("det/count", det_cnt - d0, k + 1);
    end
    bus.start_valid = 1'b0;

    // Randomized payloads and idle gaps
    for (int k = 0; k < 6; k++) begin
      idle_cycles(int'($urandom_range(0, 3)), "rnd");
      send(PW'($urandom), 1'b0, PW'($urandom), "rnd");
    end

`ifdef GEN_SEQ_PARITY_EN
    send(8'h01, 1'b0, PW'($urandom), "par01");
    send(8'hA5, 1'b0, PW'($urandom), "parA5");
`endif

    // Reset during the 3rd payload bit
    idle_cycles(2, "mid");
    bus.start_valid = 1'b1;
    bus.payload     = 8'hA5;
    build_frame(8'hA5);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.start_valid = 1'b0;
      chk("mid/a", bus.a, exp_q[i]);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid/rst_a", bus.a, 0);
    chk("mid/rst_busy", bus.busy, 0);
    chk("mid/rst_last", bus.last_bit, 0);
    chk("mid/rst_ready", bus.start_ready, 1);
    bus.start_valid = 1'b1;
    bus.payload     = 8'h3C;
    repeat (2) @(negedge clk);
    chk("mid/held_a", bus.a, 0);
    chk("mid/held_busy", bus.busy, 0);
    rst_n = 1'b1;
    #1;
    chk("mid/rel_ready", bus.start_ready, 1);
    chk("mid/rel_a", bus.a, 0);
    expect_frame(8'h3C, 1'b0, PW'($urandom), "mid_new");
    gap_check("mid_new");
    idle_cycles(2, "end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/generate_6_bit_sequence_using_fsm.md
GENERATE_6_BIT_SEQUENCE_USING_FSM -- requirements
Module: generate_6_bit_sequence_using_fsm

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 8, payload bit count per frame; legal range 1..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_valid  input  1  request to transmit one frame.
REQ-005 SHALL have port start_ready  output  1  high when a request can be accepted.
REQ-006 SHALL have port payload  input  PAYLOAD_W  frame data; sampled only on handshake.
REQ-007 SHALL have port a  output  1  serial bit stream, one bit per clk, registered.
REQ-008 SHALL have port busy  output  1  high while a frame bit is being driven on a.
REQ-009 SHALL have port last_bit  output  1  high in the same cycle as the final frame bit on a.

Function
REQ-010 SHALL use FSM states IDLE, SYNC, DATA, PAR (PAR exists only when the parity feature is compiled in).
REQ-011 SHALL accept a request when start_valid && start_ready; start_ready SHALL equal (state == IDLE).
REQ-012 SHALL, on acceptance, latch payload and drive the first sync bit on a in the next cycle (latency 1).
REQ-013 SHALL emit the sync pattern 110011 left to right in SYNC (6 cycles), then payload MSB-first in DATA (PAYLOAD_W cycles).
REQ-014 SHALL go SYNC->DATA after the 6th sync bit, DATA->PAR (feature on) or DATA->IDLE (feature off) after the last payload bit, PAR->IDLE after 1 cycle.
REQ-015 SHALL drive a = 0, busy = 0 and last_bit = 0 in IDLE.
REQ-016 SHALL assert last_bit for exactly one cycle per frame, on the final bit (last payload bit, or parity bit).
REQ-017 SHALL spend at least one cycle in IDLE between frames; back-to-back requests SHALL be separated by exactly one a = 0 bit.
REQ-018 SHALL ignore start_valid while not in IDLE; the requester holds it until accepted.
REQ-019 SHALL ignore payload changes after acceptance; the frame uses the latched value.
REQ-020 SHALL use a bit counter of width $clog2(max(6, PAYLOAD_W)+1) that resets to 0 on every state change and never wraps mid-state.

Reset
REQ-021 SHALL, on rst_n low, immediately force state IDLE, a = 0, busy = 0, last_bit = 0, counter 0, and latched payload 0, regardless of the current cycle.
REQ-022 SHALL abort a frame in progress when reset occurs mid-frame, with no resumption after release.
REQ-023 SHALL drive start_ready = 1 in the first cycle after rst_n releases; a start_valid held through reset SHALL be accepted on the first posedge after release.

Configuration
REQ-024 SHALL, when macro GEN_SEQ_PARITY_EN is defined, append one even-parity bit (XOR of the latched payload only) after the payload.
REQ-025 SHALL, when GEN_SEQ_PARITY_EN is undefined, omit the PAR state; frame length is then 6 + PAYLOAD_W.

Structure
REQ-026 SHALL take the state enum typedef, SYNC_PATTERN = 6'b110011 and SYNC_LEN = 6 from shared package gen_seq_pkg.
REQ-027 SHALL place the payload load/shift register in one sub-module, piso_shift_reg (parallel load, MSB-first shift, async active-low clear).

Verification
REQ-028 SHALL test: payload 8'hA5, feature off -> a = 1,1,0,0,1,1,1,0,1,0,0,1,0,1 from the cycle after the handshake; last_bit on the 14th bit; busy for 14 cycles.
REQ-029 SHALL test: GEN_SEQ_PARITY_EN, payloads 8'h01 then 8'hA5 -> parity bit 1 then 0; frame length 15; last_bit on the parity bit.
REQ-030 SHALL test: start_valid held high continuously -> frames repeat with exactly one a = 0 cycle between them; start_ready high only in that gap.
REQ-031 SHALL test: payload changed from 8'hA5 to 8'hFF on the cycle after acceptance -> the frame still carries A5.
REQ-032 SHALL test: rst_n pulsed low during the 3rd payload bit -> a, busy and last_bit go 0 without waiting for a clock edge; after release start_ready = 1 and a new frame transmits correctly.
REQ-033 SHALL test: loopback of a into the team's 110011 detector, payload 8'h00 -> detected asserted exactly once per frame.
